// File: rtl/mac_tx_ctrl_if.sv
// Signal bundle between the TX framing controller and its FIFO, PHY nibble bus and CRC generator.
// Member names keep the original port names so the surrounding logic maps one-to-one.
interface mac_tx_ctrl_if;
  logic [7:0]  IData;
  logic        IData_vld;
  logic        IData_last;
  logic        OData_rd;
  logic        OTx_en;
  logic [3:0]  OTx_d;
  logic        OTx_er;
  logic        OCRC_init;
  logic        OCRC_en;
  logic [7:0]  OCRC_d;
  logic [31:0] ICRC;
  logic        OBusy;
  logic        ODone;
  logic        OAbort;

  modport master (
    input  IData, IData_vld, IData_last, ICRC,
    output OData_rd, OTx_en, OTx_d, OTx_er, OCRC_init, OCRC_en, OCRC_d,
           OBusy, ODone, OAbort
  );

  modport slave (
    output IData, IData_vld, IData_last, ICRC,
    input  OData_rd, OTx_en, OTx_d, OTx_er, OCRC_init, OCRC_en, OCRC_d,
           OBusy, ODone, OAbort
  );
endinterface

// File: rtl/mac_tx_ctrl.sv
// MAC transmit framing: preamble, SFD, payload, optional pad, FCS, IFG; aborts on underrun/oversize.
// Define MAC_TX_PAD_EN to zero-pad short frames up to MIN_BYTES (pad covered by the FCS).
module mac_tx_ctrl #(
  parameter int unsigned PRE_BYTES   = 7,
  parameter int unsigned MIN_BYTES   = 60,
  parameter int unsigned MAX_BYTES   = 1514,
  parameter int unsigned IFG_NIBBLES = 24
) (
  input  logic          Clk,
  input  logic          Reset,
  mac_tx_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
`ifdef MAC_TX_PAD_EN
    S_PAD,
`endif
    S_CRC,
    S_ABORT,
    S_IFG
  } state_t;

  localparam logic [15:0] PRE_LAST = 16'(2 * PRE_BYTES - 1);
  // SIdle always contributes one idle cycle, so SIFG itself runs one short
  localparam logic [15:0] IFG_LAST = 16'(IFG_NIBBLES - 2);
  localparam logic [10:0] CNT_MAX  = 11'(MAX_BYTES);
`ifdef MAC_TX_PAD_EN
  localparam logic [10:0] CNT_MIN  = 11'(MIN_BYTES);
`endif

  state_t      state_q, state_n;
  logic        phase_q, phase_n;
  logic [10:0] cnt_q, cnt_n;
  logic [15:0] nib_q, nib_n;
  logic [3:0]  hi_q, hi_n;
  logic [31:0] crc_q, crc_n;
  logic        last_q, last_n;

  logic        rd_q, rd_n;
  logic        en_q, en_n;
  logic [3:0]  d_q, d_n;
  logic        er_q, er_n;
  logic        init_q, init_n;
  logic        crcen_q, crcen_n;
  logic [7:0]  crcd_q, crcd_n;
  logic        busy_q, busy_n;
  logic        done_q, done_n;
  logic        abort_q, abort_n;

  logic        take, to_crc, to_abort;
`ifdef MAC_TX_PAD_EN
  logic        to_pad;
`endif

  // Outputs are computed for the state being entered and registered with it
  always_comb begin
    state_n  = state_q;
    phase_n  = phase_q;
    cnt_n    = cnt_q;
    nib_n    = nib_q;
    hi_n     = hi_q;
    crc_n    = crc_q;
    last_n   = last_q;
    rd_n     = 1'b0;
    en_n     = 1'b0;
    d_n      = '0;
    er_n     = 1'b0;
    init_n   = 1'b0;
    crcen_n  = 1'b0;
    crcd_n   = '0;
    done_n   = 1'b0;
    abort_n  = 1'b0;
    take     = 1'b0;
    to_crc   = 1'b0;
    to_abort = 1'b0;
`ifdef MAC_TX_PAD_EN
    to_pad   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.IData_vld) begin
          state_n = S_PRE;
          nib_n   = '0;
          cnt_n   = '0;
          last_n  = 1'b0;
          init_n  = 1'b1;
          en_n    = 1'b1;
          d_n     = 4'h5;
        end
      end
      S_PRE: begin
        en_n = 1'b1;
        d_n  = 4'h5;
        if (nib_q == PRE_LAST) begin
          state_n = S_SFD;
          nib_n   = '0;
        end else begin
          nib_n = nib_q + 16'd1;
        end
      end
      S_SFD: begin
        if (nib_q == '0) begin
          en_n  = 1'b1;
          d_n   = 4'hD;
          nib_n = 16'd1;
        end else if (bus.IData_vld) begin
          take = 1'b1;
        end else begin
          to_abort = 1'b1;
        end
      end
      S_DATA: begin
        if (!phase_q) begin
          phase_n = 1'b1;
          en_n    = 1'b1;
          d_n     = hi_q;
        end else if (last_q) begin
`ifdef MAC_TX_PAD_EN
          if (cnt_q < CNT_MIN) to_pad = 1'b1;
          else                 to_crc = 1'b1;
`else
          to_crc = 1'b1;
`endif
        end else if (cnt_q == CNT_MAX || !bus.IData_vld) begin
          to_abort = 1'b1;
        end else begin
          take = 1'b1;
        end
      end
`ifdef MAC_TX_PAD_EN
      S_PAD: begin
        if (!phase_q) begin
          phase_n = 1'b1;
          en_n    = 1'b1;
        end else if (cnt_q == CNT_MIN) begin
          to_crc = 1'b1;
        end else begin
          to_pad = 1'b1;
        end
      end
`endif
      S_CRC: begin
        if (nib_q == 16'd7) begin
          state_n = S_IFG;
          nib_n   = '0;
        end else begin
          en_n   = 1'b1;
          d_n    = crc_q[3:0];
          crc_n  = {4'h0, crc_q[31:4]};
          nib_n  = nib_q + 16'd1;
          done_n = (nib_q == 16'd6);
        end
      end
      S_ABORT: begin
        // Pop every other cycle so the head byte has refreshed before the next pop
        if (last_q) begin
          state_n = S_IFG;
          nib_n   = '0;
        end else if (bus.IData_vld && !rd_q) begin
          rd_n   = 1'b1;
          last_n = bus.IData_last;
        end
      end
      S_IFG: begin
        if (nib_q == IFG_LAST) state_n = S_IDLE;
        else                   nib_n   = nib_q + 16'd1;
      end
      default: state_n = S_IDLE;
    endcase

    if (take) begin
      state_n = S_DATA;
      phase_n = 1'b0;
      hi_n    = bus.IData[7:4];
      last_n  = bus.IData_last;
      cnt_n   = cnt_q + 11'd1;
      rd_n    = 1'b1;
      crcen_n = 1'b1;
      crcd_n  = bus.IData;
      en_n    = 1'b1;
      d_n     = bus.IData[3:0];
    end
`ifdef MAC_TX_PAD_EN
    if (to_pad) begin
      state_n = S_PAD;
      phase_n = 1'b0;
      cnt_n   = cnt_q + 11'd1;
      crcen_n = 1'b1;
      en_n    = 1'b1;
    end
`endif
    if (to_crc) begin
      state_n = S_CRC;
      nib_n   = '0;
      crc_n   = {4'h0, bus.ICRC[31:4]};
      en_n    = 1'b1;
      d_n     = bus.ICRC[3:0];
    end
    if (to_abort) begin
      state_n = S_ABORT;
      abort_n = 1'b1;
      en_n    = 1'b1;
      er_n    = 1'b1;
    end

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      nib_q   <= '0;
      hi_q    <= '0;
      crc_q   <= '0;
      last_q  <= 1'b0;
      rd_q    <= 1'b0;
      en_q    <= 1'b0;
      d_q     <= '0;
      er_q    <= 1'b0;
      init_q  <= 1'b0;
      crcen_q <= 1'b0;
      crcd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_n;
      phase_q <= phase_n;
      cnt_q   <= cnt_n;
      nib_q   <= nib_n;
      hi_q    <= hi_n;
      crc_q   <= crc_n;
      last_q  <= last_n;
      rd_q    <= rd_n;
      en_q    <= en_n;
      d_q     <= d_n;
      er_q    <= er_n;
      init_q  <= init_n;
      crcen_q <= crcen_n;
      crcd_q  <= crcd_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      abort_q <= abort_n;
    end
  end

  assign bus.OData_rd  = rd_q;
  assign bus.OTx_en    = en_q;
  assign bus.OTx_d     = d_q;
  assign bus.OTx_er    = er_q;
  assign bus.OCRC_init = init_q;
  assign bus.OCRC_en   = crcen_q;
  assign bus.OCRC_d    = crcd_q;
  assign bus.OBusy     = busy_q;
  assign bus.ODone     = done_q;
  assign bus.OAbort    = abort_q;

endmodule

// File: tb/tb_mac_tx_ctrl.sv
// Scoreboard bench for mac_tx_ctrl: FIFO and CRC-32 generator models, expected line nibbles queued per frame.
module tb_mac_tx_ctrl;
  localparam int IFG  = 24;
  localparam int MINB = 60;
  localparam int MAXB = 1514;
`ifdef MAC_TX_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  mac_tx_ctrl_if bus ();

  mac_tx_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // External CRC generator: result visible the cycle after each accumulate strobe
  logic [31:0] crc_reg;
  always @(posedge Clk) begin
    if (bus.OCRC_init)    crc_reg <= '1;
    else if (bus.OCRC_en) crc_reg <= crc_upd(crc_reg, bus.OCRC_d);
  end
  assign bus.ICRC = ~crc_reg;

  logic [8:0] fifo[$];
  logic [4:0] exp_nib[$];
  int         exp_len[$];
  int         exp_res[$];

  int n_chk = 0, n_pass = 0;
  int done_cnt = 0, abort_cnt = 0, crc_en_cnt = 0;
  int tx_len = 0, gap = 0, gaps_seen = 0;
  bit prev_en = 1'b0, chk_gap = 1'b0, hold = 1'b0;
  int stall_at = -1, stall_len = 0, hold_cnt = 0, frame_pops = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic refresh();
    bus.IData_vld  = (fifo.size() > 0) && !hold;
    bus.IData      = (fifo.size() > 0) ? fifo[0][7:0] : 8'h00;
    bus.IData_last = (fifo.size() > 0) ? fifo[0][8] : 1'b0;
  endtask

  task automatic monitor();
    int e;
    if (bus.OCRC_init) crc_en_cnt = 0;
    if (bus.OCRC_en)   crc_en_cnt++;
    if (bus.OData_rd)  check_val("rd_needs_vld", bus.IData_vld, 1);
    if (bus.OTx_en) begin
      if (!prev_en && chk_gap) begin
        check_val("ifg_gap", gap, IFG);
        gaps_seen++;
      end
      tx_len++;
      gap = 0;
      if (exp_nib.size() == 0) check_val("nib_expected", 0, 1);
      else check_val("line_nib", {bus.OTx_er, bus.OTx_d}, exp_nib.pop_front());
    end else begin
      if (prev_en) begin
        e = (exp_len.size() > 0) ? exp_len.pop_front() : 0;
        check_val("en_len", tx_len, e);
        tx_len = 0;
      end
      gap++;
    end
    prev_en = bus.OTx_en;
    if (bus.ODone) begin
      done_cnt++;
      e = (exp_res.size() > 0) ? exp_res.pop_front() : -2;
      check_val("done_crc_en", crc_en_cnt, e);
    end
    if (bus.OAbort) begin
      abort_cnt++;
      e = (exp_res.size() > 0) ? exp_res.pop_front() : -2;
      check_val("abort_expected", e, 32'hFFFF_FFFF);
    end
  endtask

  task automatic tick();
    logic       pend;
    logic [8:0] ent;
    @(negedge Clk);
    monitor();
    pend = bus.OData_rd;
    @(posedge Clk);
    #1;
    if (hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) hold = 1'b0;
    end
    if (pend && fifo.size() > 0) begin
      ent = fifo.pop_front();
      if (ent[8]) frame_pops = 0;
      else        frame_pops++;
      if (stall_at >= 0 && frame_pops == stall_at) begin
        hold     = 1'b1;
        hold_cnt = stall_len;
        stall_at = -1;
      end
    end
    refresh();
  endtask

  // cut >= 0: frame is expected to abort after 'cut' bytes have gone out
  task automatic push_frame(input int n, input int base, input int cut);
    logic [7:0]  b;
    logic [31:0] crc;
    int          np;
    for (int i = 0; i < n; i++) begin
      b = 8'(base + i);
      fifo.push_back({(i == n - 1), b});
    end
    if (n > MAXB) cut = MAXB;
    for (int i = 0; i < 15; i++) exp_nib.push_back(5'h05);
    exp_nib.push_back(5'h0D);
    if (cut >= 0) begin
      for (int i = 0; i < cut; i++) begin
        b = 8'(base + i);
        exp_nib.push_back({1'b0, b[3:0]});
        exp_nib.push_back({1'b0, b[7:4]});
      end
      exp_nib.push_back(5'h10);
      exp_len.push_back(16 + 2 * cut + 1);
      exp_res.push_back(-1);
    end else begin
      np  = (PAD && n < MINB) ? MINB : n;
      crc = '1;
      for (int i = 0; i < np; i++) begin
        b   = (i < n) ? 8'(base + i) : 8'h00;
        crc = crc_upd(crc, b);
        exp_nib.push_back({1'b0, b[3:0]});
        exp_nib.push_back({1'b0, b[7:4]});
      end
      crc = ~crc;
      for (int k = 0; k < 8; k++) exp_nib.push_back({1'b0, crc[4*k +: 4]});
      exp_len.push_back(16 + 2 * np + 8);
      exp_res.push_back(np);
    end
  endtask

  task automatic run_idle(input string tag, input int budget);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!(fifo.size() == 0 && exp_nib.size() == 0 && !bus.OBusy && !prev_en) && k < budget);
    check_val({"idle_", tag}, fifo.size() + exp_nib.size() + exp_len.size() + exp_res.size()
                              + ((k >= budget) ? 1 : 0), 0);
  endtask

  initial begin
    int k;
    Reset = 1'b1;
    refresh();
    repeat (3) tick();
    check_val("rst_flags", {bus.OTx_en, bus.OTx_er, bus.OData_rd, bus.OCRC_init, bus.OCRC_en,
                            bus.OBusy, bus.ODone, bus.OAbort}, 0);
    check_val("rst_data", {bus.OTx_d, bus.OCRC_d}, 0);
    Reset = 1'b0;
    tick();

    done_cnt = 0;
    push_frame(64, 0, -1);
    run_idle("f64", 1000);
    check_val("f64_done", done_cnt, 1);

    done_cnt = 0;
    push_frame(10, 8'hC0, -1);
    run_idle("f10", 1000);
    check_val("f10_done", done_cnt, 1);

    done_cnt = 0;
    push_frame(20, 8'h40, -1);
    push_frame(30, 8'h60, -1);
    k = 0;
    while (tx_len == 0 && k < 200) begin tick(); k++; end
    chk_gap = 1'b1;
    run_idle("b2b", 2000);
    chk_gap = 1'b0;
    check_val("b2b_done", done_cnt, 2);
    check_val("b2b_gaps", gaps_seen, 1);

    done_cnt  = 0;
    abort_cnt = 0;
    stall_at  = 5;
    stall_len = 8;
    push_frame(20, 8'h80, 5);
    push_frame(12, 8'hA0, -1);
    run_idle("underrun", 2000);
    check_val("underrun_abort", abort_cnt, 1);
    check_val("underrun_done", done_cnt, 1);

    done_cnt  = 0;
    abort_cnt = 0;
    push_frame(1600, 0, -1);
    push_frame(8, 8'h33, -1);
    run_idle("oversize", 8000);
    check_val("oversize_abort", abort_cnt, 1);
    check_val("oversize_done", done_cnt, 1);

    push_frame(20, 8'h11, -1);
    k = 0;
    while (!(exp_nib.size() > 0 && exp_nib.size() <= 4) && k < 500) begin tick(); k++; end
    Reset = 1'b1;
    #1;
    check_val("rst_mid_en", bus.OTx_en, 0);
    check_val("rst_mid_busy", bus.OBusy, 0);
    check_val("rst_mid_fifo", fifo.size(), 0);
    exp_nib.delete();
    exp_len.delete();
    exp_res.delete();
    tx_len   = 0;
    prev_en  = 1'b0;
    done_cnt = 0;
    push_frame(16, 8'h20, -1);
    refresh();
    tick();
    Reset = 1'b0;
    tick();
    check_val("rst_accept", bus.OTx_en, 1);
    run_idle("after_rst", 1000);
    check_val("after_rst_done", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
